sample_acc_relu_11b: RTL and testbench
======================================

# sample_acc_relu_11b

Streaming accumulate/activation stage directly downstream of the 11-bit signed multiplier pipeline in the sample inference datapath. It consumes one truncated 11-bit signed product per accepted beat, sums N_TAPS products plus a bias into a wide accumulator, then scales, saturates and applies ReLU. It emits one 11-bit neuron output per vector over a valid/ready handshake. Its in_ready output drives the upstream multiplier's ce.

## Interface
- N_TAPS, 16: products per output vector; range 2..64.
- ACC_WIDTH, 18: accumulator width; must be at least 11 + clog2(N_TAPS+1).
- OUT_SHIFT, 0: arithmetic right shift applied before saturation; range 0..7.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of the partial vector; takes priority over in_valid.
- in_valid  in  1  in_data/in_bias valid.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  11  signed product from the multiplier.
- in_bias  in  11  signed bias; sampled only on the first beat of a vector.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  downstream accepts.
- out_data  out  11  ReLU output, 0..1023.
- busy  out  1  a partial vector is in progress (cnt != 0).

## Operation
- Beat accepted ⇔ in_valid && in_ready && !clear.
- Tap counter cnt runs 0..N_TAPS-1.
- Accumulation on an accepted beat:
  - cnt==0: acc <= sext(in_bias) + sext(in_data).
  - Otherwise: acc <= acc + sext(in_data).
  - cnt increments; it wraps to 0 after N_TAPS-1.
- Final beat (cnt==N_TAPS-1):
  - r = (acc + sext(in_data)) >>> OUT_SHIFT.
  - Saturate r to [-1024, 1023].
  - If the saturated value is negative, use 0.
  - Load the result into the output register; out_valid <= 1.
- Output register:
  - Cleared to out_valid=0 when out_valid && out_ready and no final beat arrives in that cycle.
  - A simultaneous final beat and output handshake reloads the register with the new result; out_valid stays 1.
- in_ready = !(cnt==N_TAPS-1 && out_valid && !out_ready).
  - Only the final beat stalls. Earlier beats of the next vector are accepted while a result waits.
- clear: cnt <= 0, acc <= 0. It does not touch the output register.
- Reset: cnt=0, acc=0, out_valid=0, out_data=0. busy=0 and in_ready=1 (N_TAPS≥2).
- The accumulator never wraps for legal parameters. A parameter check flags an ACC_WIDTH that is too small at elaboration.

## Timing
- The result appears on out_data with out_valid=1 in the cycle after the final beat is accepted (1-cycle latency).
- Throughput: one vector per N_TAPS cycles with out_ready held high; no bubble between vectors.
- in_ready is combinational from out_ready and registered state only, with no path from in_valid. It is safe as the upstream ce.
- Upstream multiplier latency is 2 cycles. The upstream controller aligns in_valid with the product; this block does not delay-match.
- out_data and out_valid are registered and stay stable while out_valid && !out_ready.
- Reset asserted mid-vector: all state clears immediately and asynchronously. Reset release is synchronized externally.

## Structure
- Shared package sample_nn_pkg:
  - PROD_W=11, OUT_W=11.
  - Saturation bounds SAT_MAX=1023, SAT_MIN=-1024.
  - A function sat_relu(acc, shift) returning the OUT_W result.
  - Typedef prod_t (signed [10:0]).
- One natural sub-module: sample_acc_relu_11b_sat, the combinational shift/saturate/ReLU. It is instantiated once and reused by sibling neuron stages.
- Top level holds cnt, acc, the output register and the handshake logic.

## Test plan
- N_TAPS=4, bias=5, products 10, -3, 7, 1, out_ready=1 → out_data=20 one cycle after the 4th beat; out_valid high one cycle.
- Saturation and ReLU:
  - bias=1000, products 1000×4 → out_data=1023.
  - bias=-1000, products -500×4 → out_data=0.
- OUT_SHIFT=2, bias=0, products 8, 8, 8, -1 → sum 23 >>> 2 = 5 → out_data=5.
- Backpressure:
  - Result pending with out_ready=0; stream the next vector → first 3 beats accepted, 4th sees in_ready=0.
  - Raise out_ready → same-cycle handshake plus final beat; out_valid stays 1 with the new value.
- Assert clear after 2 beats, then send a full vector → output reflects only the new vector plus its bias; the earlier pending output is unaffected.
- Pull reset_n low mid-vector (cnt=2) with out_valid=1 → out_valid, out_data, busy go 0 immediately; in_ready=1. The next vector starts at cnt=0 with its own bias.

Source files
------------

// File: rtl/sample_nn_pkg.sv
// Shared types, widths and the saturate/ReLU helper for the sample inference datapath.
package sample_nn_pkg;

  localparam int unsigned PROD_W    = 11;
  localparam int unsigned OUT_W     = 11;
  // Widest accumulator the helper function handles.
  localparam int unsigned ACC_MAX_W = 32;

  localparam int SAT_MAX = 1023;
  localparam int SAT_MIN = -1024;

  typedef logic signed [PROD_W-1:0] prod_t;

  // Arithmetic shift, clamp to the signed 11-bit range, then clip negatives to zero.
  function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_MAX_W-1:0] acc,
                                                input int unsigned shift);
    logic signed [ACC_MAX_W-1:0] r;
    r = acc >>> shift;
    if (r > SAT_MAX) r = SAT_MAX;
    if (r < SAT_MIN) r = SAT_MIN;
    if (r < 0)       r = '0;
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sample_acc_relu_11b_sat.sv
// Combinational shift / saturate / ReLU of a wide signed accumulator value.
//   acc_in : signed accumulator sum (ACC_WIDTH bits)
//   res_c  : OUT_W-bit non-negative result, 0..1023
module sample_acc_relu_11b_sat
  import sample_nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 18,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic        [OUT_W-1:0]     res_c
);

  assign res_c = sat_relu(ACC_MAX_W'(acc_in), OUT_SHIFT);

endmodule

// File: rtl/sample_acc_relu_11b.sv
// Streaming accumulate + activation stage: sums N_TAPS signed products plus a bias,
// then shifts, saturates and applies ReLU, emitting one result per vector.
//   clk, reset_n        : clock, async active-low reset
//   clear               : synchronous abort of the partial vector
//   in_valid/in_ready   : input handshake (in_ready doubles as upstream ce)
//   in_data, in_bias    : signed product; bias sampled on the first beat only
//   out_valid/out_ready : output handshake, out_data registered
//   busy                : partial vector in progress
module sample_acc_relu_11b
  import sample_nn_pkg::*;
#(
  parameter int unsigned N_TAPS    = 16,
  parameter int unsigned ACC_WIDTH = 18,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic [PROD_W-1:0] in_bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(N_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  // Elaboration-time parameter legality.
  if (N_TAPS < 2 || N_TAPS > 64) begin : g_bad_taps
    $error("sample_acc_relu_11b: N_TAPS must be in 2..64");
  end
  if (ACC_WIDTH < PROD_W + $clog2(N_TAPS + 1) || ACC_WIDTH > ACC_MAX_W) begin : g_bad_acc
    $error("sample_acc_relu_11b: ACC_WIDTH too small for N_TAPS (or wider than 32)");
  end
  if (OUT_SHIFT > 7) begin : g_bad_shift
    $error("sample_acc_relu_11b: OUT_SHIFT must be in 0..7");
  end

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;

  logic                        last_c;
  logic                        in_ready_c;
  logic                        accept_c;
  logic signed [ACC_WIDTH-1:0] sum_c;
  logic [OUT_W-1:0]            res_c;

  // Handshake and running sum; the bias replaces the stale accumulator on tap 0.
  always_comb begin
    last_c     = (cnt_q == LAST_TAP);
    in_ready_c = !(last_c && out_valid_q && !out_ready);
    accept_c   = in_valid && in_ready_c && !clear;
    sum_c      = ((cnt_q == '0) ? ACC_WIDTH'($signed(in_bias)) : acc_q)
               + ACC_WIDTH'($signed(in_data));
  end

  sample_acc_relu_11b_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_sat (
    .acc_in (sum_c),
    .res_c  (res_c)
  );

  // Next-state: drain on handshake first, a final beat then reloads the output.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept_c) begin
      acc_d = sum_c;
      if (last_c) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = res_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign busy      = (cnt_q != '0);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sample_acc_relu_11b.sv
// Bench for sample_acc_relu_11b: two instances (OUT_SHIFT 0 and 2) share stimulus and
// are compared against a vector-level reference model.
module tb_sample_acc_relu_11b;

  localparam int N = 4;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [10:0] in_data;
  logic [10:0] in_bias;
  logic        out_ready;
  logic        ir0, ov0, busy0;
  logic        ir2, ov2, busy2;
  logic [10:0] od0, od2;

  int checks   = 0;
  int failures = 0;

  // Reference model state: tap count, running sum, pending output.
  int m_cnt = 0;
  int m_sum = 0;
  bit m_ov  = 0;
  int m_od0 = 0;
  int m_od2 = 0;

  sample_acc_relu_11b #(.N_TAPS(N), .ACC_WIDTH(14), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_bias(in_bias), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .busy(busy0));

  sample_acc_relu_11b #(.N_TAPS(N), .ACC_WIDTH(14), .OUT_SHIFT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .in_bias(in_bias), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .busy(busy2));

  always #5 clk = ~clk;

  function automatic int ref_out(input int sum, input int sh);
    int r;
    r = sum >>> sh;
    if (r > 1023)  r = 1023;
    if (r < -1024) r = -1024;
    if (r < 0)     r = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step(output bit acc);
    bit exp_rdy, fin, hs;
    int d, b;
    @(negedge clk);
    exp_rdy = !(m_cnt == N - 1 && m_ov && !out_ready);
    chk("in_ready_s0", 32'(ir0), 32'(exp_rdy));
    chk("in_ready_s2", 32'(ir2), 32'(exp_rdy));
    chk("busy_s0", 32'(busy0), 32'(m_cnt != 0));
    chk("busy_s2", 32'(busy2), 32'(m_cnt != 0));
    chk("out_valid_s0", 32'(ov0), 32'(m_ov));
    chk("out_valid_s2", 32'(ov2), 32'(m_ov));
    if (m_ov) begin
      chk("out_data_s0", 32'(od0), 32'(m_od0));
      chk("out_data_s2", 32'(od2), 32'(m_od2));
    end
    acc = in_valid && exp_rdy && !clear;
    fin = acc && (m_cnt == N - 1);
    hs  = m_ov && out_ready;
    d   = int'($signed(in_data));
    b   = int'($signed(in_bias));
    if (clear) begin
      m_cnt = 0;
      m_sum = 0;
    end else if (acc) begin
      m_sum = (m_cnt == 0) ? b + d : m_sum + d;
      if (fin) begin
        m_od0 = ref_out(m_sum, 0);
        m_od2 = ref_out(m_sum, 2);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (fin) m_ov = 1'b1;
    else if (hs) m_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted (bounded).
  task automatic send(input int b, input int d);
    bit a;
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_bias  = 11'(b);
    in_data  = 11'(d);
    do begin
      step(a);
      tries++;
    end while (!a && tries < 40);
    in_valid = 1'b0;
    if (!a) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic send_vec(input int b, input int p0, input int p1, input int p2, input int p3);
    send(b, p0);
    send(b, p1);
    send(b, p2);
    send(b, p3);
  endtask

  // Directed check of a freshly loaded result against hand-computed constants.
  task automatic peek(input string tag, input int e0, input int e2);
    #1;
    chk({tag, "_valid"}, 32'(ov0), 32'(1));
    chk({tag, "_s0"}, 32'(od0), 32'(e0));
    chk({tag, "_s2"}, 32'(od2), 32'(e2));
  endtask

  initial begin
    bit a;
    clk       = 1'b0;
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bias   = '0;
    out_ready = 1'b1;

    // Reset values.
    #12;
    chk("rst_out_valid", 32'(ov0), 32'(0));
    chk("rst_out_data", 32'(od0), 32'(0));
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_in_ready", 32'(ir0), 32'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic vector, then out_valid must drop after one handshake cycle.
    send_vec(5, 10, -3, 7, 1);
    peek("basic", 20, 5);
    step(a);
    #1;
    chk("basic_one_cycle", 32'(ov0), 32'(0));

    // Saturation high and ReLU.
    send_vec(1000, 1000, 1000, 1000, 1000);
    peek("sat_hi", 1023, 1023);
    send_vec(-1000, -500, -500, -500, -500);
    peek("relu", 0, 0);

    // Shift rounding: 23 >>> 2 = 5.
    send_vec(0, 8, 8, 8, -1);
    peek("shift", 23, 5);
    step(a);

    // Backpressure: result pending, next vector's final beat stalls.
    out_ready = 1'b0;
    send_vec(2, 1, 2, 3, 4);
    peek("bp_a", 12, 3);
    send(-7, 100);
    send(-7, 50);
    send(-7, -20);
    #1;
    chk("bp_ready_low", 32'(ir0), 32'(0));
    chk("bp_busy", 32'(busy0), 32'(1));
    chk("bp_hold", 32'(od0), 32'(12));
    in_valid = 1'b1;
    in_data  = 11'(30);
    step(a);
    #1;
    chk("bp_hold2", 32'(od0), 32'(12));
    chk("bp_hold2_valid", 32'(ov0), 32'(1));
    out_ready = 1'b1;
    step(a);
    in_valid = 1'b0;
    peek("bp_b", 153, 38);

    // Clear mid-vector leaves the pending result alone.
    out_ready = 1'b0;
    send(400, 300);
    send(400, 300);
    clear    = 1'b1;
    in_valid = 1'b1;
    step(a);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_busy", 32'(busy0), 32'(0));
    chk("clr_hold", 32'(od0), 32'(153));
    chk("clr_hold_valid", 32'(ov0), 32'(1));
    send(-4, 10);
    send(-4, 20);
    send(-4, 30);
    out_ready = 1'b1;
    send(-4, 40);
    peek("clr_new", 96, 24);

    // Async reset mid-vector with a result pending.
    out_ready = 1'b0;
    send(9, 1);
    send(9, 1);
    #1;
    chk("pre_rst_busy", 32'(busy0), 32'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov0), 32'(0));
    chk("mid_rst_out_data", 32'(od0), 32'(0));
    chk("mid_rst_out_data_s2", 32'(od2), 32'(0));
    chk("mid_rst_busy", 32'(busy0), 32'(0));
    chk("mid_rst_in_ready", 32'(ir0), 32'(1));
    m_cnt = 0;
    m_sum = 0;
    m_ov  = 1'b0;
    m_od0 = 0;
    m_od2 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_vec(3, 1, 2, 3, 4);
    peek("post_rst", 13, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) begin
        in_data = ($urandom_range(0, 1) == 0) ? 11'h3FF : 11'h400;
        in_bias = ($urandom_range(0, 1) == 0) ? 11'h3FF : 11'h400;
      end else begin
        in_data = 11'($urandom);
        in_bias = 11'($urandom);
      end
      step(a);
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step(a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
